// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: pops words from the TX async FIFO read port and hands them
// one at a time to the UART transmitter. Acceptance is the rising edge of
// TX_BUSY; the pop pulse follows acceptance, and the next word only launches
// after the frame has finished and the optional inter-frame gap has elapsed.
// A handshake that never gets a TX_BUSY rise is abandoned after TIMEOUT_CYC
// cycles without popping, so the same word is retried.
//
// Handshake contract: TX_DATA_VALID rises together with a stable TX_P_DATA
// and stays high until the UART raises TX_BUSY (accept) or the timeout
// expires. FIFO_RD_INC is a single-cycle pulse issued only on accept, so at
// most one pop happens per frame.
`timescale 1ns/1ps

module uart_tx_feeder #(
    parameter int DATA_WIDTH  = 8,
    parameter int GAP_CYCLES  = 0,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  TX_EN,
    input  logic                  FIFO_EMPTY,
    input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
    output logic                  FIFO_RD_INC,
    input  logic                  TX_BUSY,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_DATA_VALID,
    output logic                  TX_TIMEOUT,
    output logic [15:0]           FRAME_CNT,
    output logic [1:0]            STATE_DBG
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_VALID = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    // Counter widths; TIMEOUT_CYC is at least 2 so TMO_W is at least 1.
    localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    // After a frame (or an abandoned handshake) either rest in GAP or go straight home.
    localparam logic [1:0] S_AFTER = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

    logic [1:0]            state_q,     state_d;
    logic                  busy_q,      busy_d;
    logic [DATA_WIDTH-1:0] data_q,      data_d;
    logic                  valid_q,     valid_d;
    logic                  rd_inc_q,    rd_inc_d;
    logic                  timeout_q,   timeout_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic [TMO_W-1:0]      tmo_cnt_q,   tmo_cnt_d;
    logic [GAP_W-1:0]      gap_cnt_q,   gap_cnt_d;
    logic                  busy_rise;

    assign busy_rise = TX_BUSY & ~busy_q;

    // Next-state and datapath decisions for the launch/accept/finish sequence.
    always_comb begin
        state_d     = state_q;
        busy_d      = TX_BUSY;
        data_d      = data_q;
        valid_d     = valid_q;
        rd_inc_d    = 1'b0;
        timeout_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (TX_EN && !FIFO_EMPTY && !TX_BUSY) begin
                    data_d    = FIFO_RD_DATA;
                    valid_d   = 1'b1;
                    tmo_cnt_d = '0;
                    state_d   = S_VALID;
                end
            end
            S_VALID: begin
                // Acceptance takes priority over a timeout on the same cycle.
                if (busy_rise) begin
                    valid_d  = 1'b0;
                    rd_inc_d = 1'b1;
                    state_d  = S_BUSY;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    valid_d   = 1'b0;
                    timeout_d = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = S_AFTER;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            S_BUSY: begin
                if (!TX_BUSY) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    gap_cnt_d   = '0;
                    state_d     = S_AFTER;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            rd_inc_q    <= 1'b0;
            timeout_q   <= 1'b0;
            frame_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            rd_inc_q    <= rd_inc_d;
            timeout_q   <= timeout_d;
            frame_cnt_q <= frame_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign TX_P_DATA     = data_q;
    assign TX_DATA_VALID = valid_q;
    assign FIFO_RD_INC   = rd_inc_q;
    assign TX_TIMEOUT    = timeout_q;
    assign FRAME_CNT     = frame_cnt_q;
    assign STATE_DBG     = state_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder with GAP_CYCLES=3, TIMEOUT_CYC=8. A queue-based
// FIFO model feeds the DUT and pops on FIFO_RD_INC; a UART model raises
// TX_BUSY after a chosen number of valid cycles. The reference model keeps
// the words that must be delivered, in order, plus expected frame, pop and
// timeout totals, and derives handshake lengths and gap spacing from the
// transaction rules.
`timescale 1ns/1ps

module tb_uart_tx_feeder;

    localparam int GAP = 3;
    localparam int TMO = 8;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        rst_n;
    logic        tx_en;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_rd_inc;
    logic        tx_busy;
    logic [7:0]  tx_p_data;
    logic        tx_data_valid;
    logic        tx_timeout;
    logic [15:0] frame_cnt;
    logic [1:0]  state_dbg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_feeder #(
        .DATA_WIDTH (8),
        .GAP_CYCLES (GAP),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .CLK          (clk),
        .RST          (rst_n),
        .TX_EN        (tx_en),
        .FIFO_EMPTY   (fifo_empty),
        .FIFO_RD_DATA (fifo_data),
        .FIFO_RD_INC  (fifo_rd_inc),
        .TX_BUSY      (tx_busy),
        .TX_P_DATA    (tx_p_data),
        .TX_DATA_VALID(tx_data_valid),
        .TX_TIMEOUT   (tx_timeout),
        .FRAME_CNT    (frame_cnt),
        .STATE_DBG    (state_dbg)
    );

    // ---------------- models / scoreboard ----------------
    logic [7:0]  fifo_q[$];     // FIFO contents as seen by the DUT
    logic [7:0]  exp_q[$];      // words still to be delivered, in order
    logic [15:0] exp_frames;
    int          exp_pops;
    int          exp_tmos;
    int          pops;
    int          tmos;
    int          n_checks;
    int          n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic refresh_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
    endtask

    task automatic push_word(input logic [7:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        refresh_fifo();
    endtask

    // FIFO pop side and pulse counters, sampled at negedge.
    initial begin
        logic [7:0] tmp;
        forever begin
            @(negedge clk);
            if (rst_n && fifo_rd_inc) begin
                pops++;
                if (fifo_q.size() > 0) tmp = fifo_q.pop_front();
                refresh_fifo();
            end
            if (rst_n && tx_timeout) tmos++;
        end
    end

    // ---------------- driver: one handshake ----------------
    // vlen: number of valid cycles before the UART accepts; hold: busy length.
    // exp_wait: expected idle negedges before valid appears (-1 = unchecked).
    task automatic do_frame(input int vlen, input int hold, input bit accept,
                            input int exp_wait, input bit drop_en);
        int         w;
        int         cnt;
        bit         acc;
        logic [7:0] tmp;
        w = 0;
        while (!tx_data_valid && w < 300) begin
            w++;
            @(negedge clk);
        end
        if (!tx_data_valid) begin
            check("launch", 32'd0, 32'd1);
            return;
        end
        if (exp_wait >= 0) check("gap_wait", w, exp_wait);
        if (exp_q.size() == 0) begin
            check("unexpected_launch", 32'd1, 32'd0);
            return;
        end
        check("data", tx_p_data, exp_q[0]);
        acc = accept && (vlen >= 1) && (vlen <= TMO);
        cnt = 1;
        forever begin
            if (acc && cnt == vlen) begin
                tx_busy = 1'b1;
                if (drop_en) tx_en = 1'b0;
            end
            @(negedge clk);
            if (!tx_data_valid || cnt > 4 * TMO) break;
            cnt++;
        end
        check("valid_len", cnt, acc ? vlen : TMO);
        check("rd_inc", fifo_rd_inc, acc);
        check("timeout", tx_timeout, !acc);
        if (acc) begin
            tmp        = exp_q.pop_front();
            exp_pops   = exp_pops + 1;
            exp_frames = exp_frames + 16'd1;
            repeat (hold - 1) @(negedge clk);
            tx_busy = 1'b0;
            @(negedge clk);
            check("frame_cnt", frame_cnt, exp_frames);
            check("pops", pops, exp_pops);
            check("timeouts", tmos, exp_tmos);
        end else begin
            exp_tmos = exp_tmos + 1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int bad;
        int w;
        int iter;
        bit first;
        n_checks = 0; n_errors = 0;
        pops = 0; tmos = 0; exp_pops = 0; exp_tmos = 0; exp_frames = 16'd0;
        rst_n = 1'b0; tx_en = 1'b0; tx_busy = 1'b0;
        refresh_fifo();

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_valid",  tx_data_valid, 1'b0);
        check("rst_rd_inc", fifo_rd_inc, 1'b0);
        check("rst_tmo",    tx_timeout, 1'b0);
        check("rst_frames", frame_cnt, 16'd0);
        check("rst_pdata",  tx_p_data, 8'h00);
        rst_n = 1'b1;
        tx_en = 1'b1;
        @(negedge clk);

        // Single word: valid for 3 cycles, busy held 10 cycles
        @(posedge clk); #1;
        push_word(8'hA5);
        do_frame(3, 10, 1'b1, -1, 1'b0);

        // Back-to-back burst with a 3-cycle gap
        @(posedge clk); #1;
        push_word(8'h01); push_word(8'h02); push_word(8'h03);
        do_frame(2, 4, 1'b1, -1, 1'b0);
        do_frame(1, 3, 1'b1, GAP + 1, 1'b0);
        do_frame(4, 5, 1'b1, GAP + 1, 1'b0);
        check("burst_frames", frame_cnt, 16'd4);

        // Timeout, then the same word retried and accepted
        @(posedge clk); #1;
        push_word(8'h3C);
        do_frame(0, 2, 1'b0, -1, 1'b0);
        do_frame(2, 3, 1'b1, GAP + 1, 1'b0);

        // Acceptance on the very cycle the timeout limit is reached
        @(posedge clk); #1;
        push_word(8'h7E);
        do_frame(TMO, 3, 1'b1, -1, 1'b0);

        // TX_EN dropped during BUSY: frame completes, no relaunch until re-enabled
        @(posedge clk); #1;
        push_word(8'h11); push_word(8'h22);
        do_frame(2, 4, 1'b1, -1, 1'b1);
        bad = 0;
        repeat (10) begin
            if (tx_data_valid) bad++;
            @(negedge clk);
        end
        check("no_launch_en0", bad, 0);
        tx_en = 1'b1;
        do_frame(2, 3, 1'b1, 1, 1'b0);

        // Reset during VALID: async clear, word relaunched unpopped
        @(posedge clk); #1;
        push_word(8'h5C);
        w = 0;
        while (!tx_data_valid && w < 50) begin
            w++;
            @(negedge clk);
        end
        check("mid_launch", tx_data_valid, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid",  tx_data_valid, 1'b0);
        check("async_rd_inc", fifo_rd_inc, 1'b0);
        check("async_frames", frame_cnt, 16'd0);
        exp_frames = 16'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_frame(2, 3, 1'b1, -1, 1'b0);
        check("fifo_after_rst", fifo_q.size(), 0);

        // Randomized traffic, some handshakes exceeding the timeout
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) push_word(8'($urandom_range(0, 255)));
        first = 1'b1;
        iter  = 0;
        while (exp_q.size() > 0 && iter < 80) begin
            do_frame($urandom_range(1, 10), $urandom_range(2, 6), 1'b1,
                     first ? -1 : GAP + 1, 1'b0);
            first = 1'b0;
            iter++;
        end
        check("rand_drain", exp_q.size(), 0);
        check("fifo_drain", fifo_q.size(), 0);

        // Frame counter wrap
        repeat (2) @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.frame_cnt_q;
        @(negedge clk);
        exp_frames = 16'hFFFE;
        check("preload", frame_cnt, exp_frames);
        @(posedge clk); #1;
        push_word(8'hC3); push_word(8'h3C);
        do_frame(2, 3, 1'b1, -1, 1'b0);
        do_frame(3, 2, 1'b1, GAP + 1, 1'b0);
        check("wrap", frame_cnt, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time limit
    initial begin
        #900000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
